// File: rtl/debouncer_pkg.sv
// Shared types and defaults for the keypad debouncer.
package debouncer_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 960000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

endpackage

// File: rtl/debouncer_counter.sv
// Clear/enable stability counter that saturates at MAX and flags completion.
module debounce_counter #(
  parameter int MAX   = 960000,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == CNT_W'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Keypad debouncer: publishes a key code once the press has been stable for
// DEBOUNCE_CYCLES clocks, then waits for an equally stable release.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sig_in,
  input  logic       key_pressed,
  output logic [3:0] sig_out
);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       code_q;
  logic [CNT_W-1:0] counter;
  logic             counter_done;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cap_code;
  logic             load_out;

  debounce_counter #(
    .MAX   (DEBOUNCE_CYCLES),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (counter),
    .done  (counter_done)
  );

  // key_pressed changes are tested before counter_done so a bounce always wins.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    cap_code  = 1'b0;
    load_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_pressed) begin
          cap_code  = 1'b1;
          state_nxt = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!key_pressed) begin
          state_nxt = IDLE;
        end else if (sig_in != code_q) begin
          cap_code = 1'b1;
        end else if (counter_done) begin
          load_out  = 1'b1;
          state_nxt = HELD;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      HELD: begin
        if (!key_pressed) begin
          state_nxt = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (key_pressed) begin
          state_nxt = HELD;
        end else if (counter_done) begin
          state_nxt = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      code_q  <= 4'h0;
      sig_out <= 4'h0;
    end else begin
      state <= state_nxt;
      if (cap_code) code_q  <= sig_in;
      if (load_out) sig_out <= code_q;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Randomized and directed bench for debouncer against a run-length reference model.
module tb_debouncer;
  import debouncer_pkg::*;

  localparam int D      = 20;
  localparam int QUAL_N = D + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sig_in;
  logic       key_pressed;
  logic [3:0] sig_out;

  int checks = 0;
  int errors = 0;

  // Reference: debounced level plus length of the current run of opposite-level samples.
  bit         m_level;
  int         m_run;
  logic [3:0] m_code;
  logic [3:0] m_exp;

  debouncer #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .key_pressed (key_pressed),
    .sig_out     (sig_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 1'b0;
    m_run   = 0;
    m_code  = 4'h0;
    m_exp   = 4'h0;
  endtask

  task automatic model_edge(input logic kp, input logic [3:0] code);
    if (!m_level) begin
      if (kp) begin
        if (m_run > 0 && code == m_code) m_run++;
        else begin
          m_run  = 1;
          m_code = code;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == QUAL_N) begin
        m_exp   = m_code;
        m_level = 1'b1;
        m_run   = 0;
      end
    end else begin
      if (!kp) m_run++;
      else     m_run = 0;
      if (m_run == QUAL_N) begin
        m_level = 1'b0;
        m_run   = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(key_pressed, sig_in);
    #1;
    check("sig_out_cycle", {28'h0, sig_out}, {28'h0, m_exp});
  endtask

  task automatic drive(input logic kp, input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      key_pressed = kp;
      sig_in      = code;
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    key_pressed = 1'b0;
    sig_in      = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    drive(1'b0, 4'h0, 5);
    check("reset_sig_out", {28'h0, sig_out}, 32'h0);
    check("reset_counter", 32'(dut.counter), 32'h0);

    // clean press: exact qualification edge
    drive(1'b1, 4'hA, QUAL_N - 1);
    check("press_before_qual", {28'h0, sig_out}, 32'h0);
    drive(1'b1, 4'hA, 1);
    check("press_at_qual", {28'h0, sig_out}, 32'hA);
    drive(1'b1, 4'hA, 40 - QUAL_N);
    drive(1'b0, 4'hA, 40);
    check("release_holds", {28'h0, sig_out}, 32'hA);

    // press bounce
    drive(1'b1, 4'h5, 1);
    drive(1'b0, 4'h5, 1);
    drive(1'b1, 4'h5, 1);
    drive(1'b0, 4'h5, 1);
    check("bounce_no_change", {28'h0, sig_out}, 32'hA);
    drive(1'b1, 4'h5, QUAL_N - 1);
    check("bounce_before_qual", {28'h0, sig_out}, 32'hA);
    drive(1'b1, 4'h5, 1);
    check("bounce_qual", {28'h0, sig_out}, 32'h5);
    drive(1'b1, 4'h5, 40 - QUAL_N);
    drive(1'b0, 4'h5, 40);

    // short press
    drive(1'b1, 4'h3, 10);
    drive(1'b0, 4'h3, 10);
    check("short_press", {28'h0, sig_out}, 32'h5);

    // release bounce while held
    drive(1'b1, 4'hC, 30);
    check("held_code", {28'h0, sig_out}, 32'hC);
    drive(1'b0, 4'hC, 5);
    drive(1'b1, 4'hC, 40);
    check("release_bounce_out", {28'h0, sig_out}, 32'hC);
    check("release_bounce_state", 32'(dut.state), 32'(HELD));
    drive(1'b0, 4'hC, 40);
    check("back_idle", 32'(dut.state), 32'(IDLE));

    // code change mid press restarts the count
    drive(1'b1, 4'h1, 15);
    drive(1'b1, 4'h2, QUAL_N - 1);
    check("recapture_before", {28'h0, sig_out}, 32'hC);
    drive(1'b1, 4'h2, 1);
    check("recapture_qual", {28'h0, sig_out}, 32'h2);
    drive(1'b0, 4'h2, 30);

    // random segments
    for (int s = 0; s < 60; s++) begin
      logic       kp;
      logic [3:0] code;
      int         len;
      kp   = 1'($urandom_range(0, 1));
      code = 4'($urandom_range(0, 15));
      len  = $urandom_range(1, 30);
      drive(kp, code, len);
    end
    drive(1'b0, 4'h0, 30);

    // asynchronous reset in the middle of a press
    drive(1'b1, 4'h7, 10);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("async_sig_out", {28'h0, sig_out}, 32'h0);
    check("async_counter", 32'(dut.counter), 32'h0);
    check("async_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    key_pressed = 1'b0;
    drive(1'b0, 4'h7, 5);
    check("post_reset_out", {28'h0, sig_out}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
